// File: rtl/tmr_pulse_capture_pkg.sv
// Shared timer definitions: prescale select encodings, capture FSM states
// and the default counter width with its saturation value.
package tmr_pulse_capture_pkg;

    typedef enum logic [1:0] {
        PS_DIV1    = 2'd0,
        PS_DIV8    = 2'd1,
        PS_DIV64   = 2'd2,
        PS_DIV8192 = 2'd3
    } ps_sel_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } cap_state_e;

    localparam int unsigned DEF_BIT_WIDTH = 8;
    localparam logic [DEF_BIT_WIDTH-1:0] CNT_SAT = '1;

endpackage

// File: rtl/tmr_edge_sync.sv
// Two-flop synchroniser plus history flop for an asynchronous timer pin;
// flags single-cycle rising and falling edges of the synchronised level.
module tmr_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pin_i,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= pin_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~s3_q;
    assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/tmr_pulse_capture.sv
// Input capture for a timer pulse output: measures high width and
// rise-to-rise period in prescaled ticks, with strobe and sticky flags.
module tmr_pulse_capture
    import tmr_pulse_capture_pkg::*;
#(
    parameter int unsigned BIT_WIDTH      = DEF_BIT_WIDTH,
    parameter int unsigned PRESCALE_WIDTH = 13
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [1:0]           prescale_sel,
    input  logic                 pulse_in,
    input  logic                 irq_clr,
    output logic [BIT_WIDTH-1:0] high_width,
    output logic [BIT_WIDTH-1:0] period,
    output logic                 width_ovf,
    output logic                 capture_valid,
    output logic                 capture_irq,
    output logic                 overrun
);

    localparam logic [BIT_WIDTH-1:0] SAT = '1;

    logic                      rise;
    logic                      fall;
    logic                      tick;
    logic [PRESCALE_WIDTH-1:0] pre_q;
    logic [PRESCALE_WIDTH-1:0] pre_d;
    logic [BIT_WIDTH-1:0]      hi_q;
    logic [BIT_WIDTH-1:0]      per_q;
    logic [BIT_WIDTH-1:0]      hi_inc;
    logic [BIT_WIDTH-1:0]      per_inc;
    logic [BIT_WIDTH-1:0]      per_pub;
    cap_state_e                state_q;

    logic [BIT_WIDTH-1:0]      high_width_q;
    logic [BIT_WIDTH-1:0]      period_q;
    logic                      width_ovf_q;
    logic                      capture_valid_q;
    logic                      capture_irq_q;
    logic                      overrun_q;

    tmr_edge_sync u_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .pin_i  (pulse_in),
        .rise_o (rise),
        .fall_o (fall)
    );

    always_comb begin
        tick = 1'b1;
        case (ps_sel_e'(prescale_sel))
            PS_DIV1:    tick = 1'b1;
            PS_DIV8:    tick = &pre_q[2:0];
            PS_DIV64:   tick = &pre_q[5:0];
            PS_DIV8192: tick = &pre_q[12:0];
            default:    tick = 1'b1;
        endcase
    end

    always_comb begin
        pre_d   = en ? pre_q + PRESCALE_WIDTH'(1) : '0;
        hi_inc  = (hi_q == SAT)  ? hi_q  : hi_q + BIT_WIDTH'(1);
        per_inc = (per_q == SAT) ? per_q : per_q + BIT_WIDTH'(1);
        per_pub = tick ? per_inc : per_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    // irq_clr is applied first so that a same-cycle publish overrides it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            hi_q            <= '0;
            per_q           <= '0;
            high_width_q    <= '0;
            period_q        <= '0;
            width_ovf_q     <= 1'b0;
            capture_valid_q <= 1'b0;
            capture_irq_q   <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            capture_valid_q <= 1'b0;
            if (irq_clr) begin
                capture_irq_q <= 1'b0;
                overrun_q     <= 1'b0;
            end
            if (!en) begin
                state_q <= IDLE;
                hi_q    <= '0;
                per_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            state_q <= HIGH;
                            hi_q    <= '0;
                            per_q   <= '0;
                        end
                    end
                    HIGH: begin
                        if (tick) begin
                            hi_q  <= hi_inc;
                            per_q <= per_inc;
                        end
                        if (fall) begin
                            state_q <= LOW;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            high_width_q    <= hi_q;
                            period_q        <= per_pub;
                            width_ovf_q     <= (hi_q == SAT) || (per_pub == SAT);
                            capture_valid_q <= 1'b1;
                            capture_irq_q   <= 1'b1;
                            if (capture_irq_q) begin
                                overrun_q <= 1'b1;
                            end
                            state_q <= HIGH;
                            hi_q    <= '0;
                            per_q   <= '0;
                        end else if (tick) begin
                            per_q <= per_inc;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        hi_q    <= '0;
                        per_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign high_width    = high_width_q;
    assign period        = period_q;
    assign width_ovf     = width_ovf_q;
    assign capture_valid = capture_valid_q;
    assign capture_irq   = capture_irq_q;
    assign overrun       = overrun_q;

endmodule
